// File: rtl/icu_pkg.sv
// Shared definitions for the vectored interrupt control unit: FSM state
// encoding, injected push opcodes and a width helper for source indices.
package icu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        PUSH_CCR = 3'd2,
        PUSH_PCL = 3'd3,
        PUSH_PCH = 3'd4,
        VECTOR   = 3'd5
    } icu_state_e;

    // Register IDs encoded in the low nibble of a push instruction
    localparam logic [3:0] PCL = 4'd8;
    localparam logic [3:0] PCH = 4'd9;
    localparam logic [3:0] CCR = 4'd10;

    localparam logic [15:0] PUSH_BASE       = 16'h6000;
    localparam logic [15:0] NOP_OP          = 16'h0000;
    localparam logic [15:0] PUSH_CCR_OP     = PUSH_BASE | {12'h000, CCR};
    localparam logic [15:0] PUSH_PC_LOW_OP  = PUSH_BASE | {12'h000, PCL};
    localparam logic [15:0] PUSH_PC_HIGH_OP = PUSH_BASE | {12'h000, PCH};

    // Width of a source index; a single source still needs one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icu_prio_arb.sv
// Combinational fixed-priority arbiter: the lowest set index wins.
module icu_prio_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    // Scan from the top down so the lowest eligible index is written last
    always_comb begin
        valid_o = |eligible_i;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/icu_vectored.sv
// Multi-source vectored interrupt control unit. Arbitrates pending sources,
// injects a NOP drain and CCR/PC-low/PC-high pushes into decode, then loads
// the winning source's vector into the PC.
// Optional build macro ICU_LEVEL_TRIG_EN: requests are level-sensitive
// (pending follows int_req directly); otherwise rising edges are latched.
module icu_vectored
    import icu_pkg::*;
#(
    parameter int          NUM_SRC      = 4,
    parameter int          PC_W         = 32,
    parameter int          INSTR_W      = 16,
    parameter int          STALL_CYCLES = 1,
    parameter int unsigned VEC_BASE     = 0,
    parameter int unsigned VEC_STRIDE   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_SRC-1:0]              int_req,
    input  logic [NUM_SRC-1:0]              int_mask,
    output logic                            stall,
    output logic                            inject,
    output logic [INSTR_W-1:0]              instruction,
    output logic                            pc_load,
    output logic [PC_W-1:0]                 pc_value,
    output logic [NUM_SRC-1:0]              ack,
    output logic                            busy,
    output logic [id_width(NUM_SRC)-1:0]    cur_id
);

    localparam int         ID_W     = id_width(NUM_SRC);
    localparam logic [2:0] CNT_LAST = 3'(STALL_CYCLES - 1);

    icu_state_e         state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] id_onehot;
    logic               win_vld;
    logic [ID_W-1:0]    win_idx;
    logic [PC_W-1:0]    vec_addr;

    // One-hot decode of the source currently being served
    always_comb begin
        id_onehot       = '0;
        id_onehot[id_q] = 1'b1;
    end

`ifdef ICU_LEVEL_TRIG_EN
    assign pending = int_req;
`else
    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;

    // New edges set pending and win over the end-of-VECTOR clear
    always_comb begin
        pending_d = pending_q;
        if (state_q == VECTOR) begin
            pending_d = pending_d & ~id_onehot;
        end
        pending_d = pending_d | (int_req & ~req_q);
    end

    // Edge-capture registers; pending survives enable drops but not reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            req_q     <= int_req;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`endif

    assign eligible = pending & ~int_mask;

    icu_prio_arb #(
        .N     (NUM_SRC),
        .IDX_W (ID_W)
    ) u_arb (
        .eligible_i (eligible),
        .valid_o    (win_vld),
        .index_o    (win_idx)
    );

    assign vec_addr = PC_W'(VEC_BASE) + PC_W'(id_q) * PC_W'(VEC_STRIDE);
    assign busy     = (state_q != IDLE);
    assign cur_id   = id_q;

    // FSM state, drain counter and served-source registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    // Next-state and output decode; enable low always steers back to IDLE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        stall       = 1'b0;
        inject      = 1'b0;
        instruction = INSTR_W'(NOP_OP);
        pc_load     = 1'b0;
        pc_value    = '0;
        ack         = '0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    id_d    = win_idx;
                end
            end
            DRAIN: begin
                stall  = 1'b1;
                inject = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = PUSH_CCR;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            PUSH_CCR: begin
                inject      = 1'b1;
                instruction = INSTR_W'(PUSH_CCR_OP);
                state_d     = PUSH_PCL;
            end
            PUSH_PCL: begin
                inject      = 1'b1;
                instruction = INSTR_W'(PUSH_PC_LOW_OP);
                state_d     = PUSH_PCH;
            end
            PUSH_PCH: begin
                inject      = 1'b1;
                instruction = INSTR_W'(PUSH_PC_HIGH_OP);
                state_d     = VECTOR;
            end
            VECTOR: begin
                inject   = 1'b1;
                pc_load  = 1'b1;
                pc_value = vec_addr;
                ack      = id_onehot;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
    end

endmodule
